// File: rtl/rv32i_types.sv
// Shared rv32i datapath types, plus the stall/flush sequencer state.
package rv32i_types;

  typedef logic [31:0] rv32i_word;
  typedef logic [4:0]  rv32i_reg;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } pctrl_state_t;

  function automatic logic is_load(input rv32i_opcode op);
    return op == op_load;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use compare: the EX load's destination is read by the ID instruction.
module hazard_detect
  import rv32i_types::*;
(
  input  rv32i_opcode ex_opcode,
  input  rv32i_reg    ex_rd,
  input  rv32i_reg    id_rs1,
  input  rv32i_reg    id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  output logic        hazard
);

  logic rs1_hit;
  logic rs2_hit;

  // x0 never carries a value, so a load into it cannot create a dependency.
  assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
  assign hazard  = is_load(ex_opcode) && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: drives per-stage load/flush,
// defers redirects that collide with an I-cache miss, and counts stalls/flushes.
module pipeline_ctrl
  import rv32i_types::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_mem_read,
  input  logic             i_mem_resp,
  input  logic             d_mem_read,
  input  logic             d_mem_write,
  input  logic             d_mem_resp,
  input  rv32i_opcode      id_opcode,
  input  rv32i_reg         id_rs1,
  input  rv32i_reg         id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  rv32i_opcode      ex_opcode,
  input  rv32i_reg         ex_rd,
  input  logic             ex_mispredict,
  input  rv32i_word        ex_target,
  output logic             load_pc,
  output logic             pc_redirect_sel,
  output rv32i_word        pc_redirect_out,
  output logic             load_if_id,
  output logic             flush_if_id,
  output logic             load_id_ex,
  output logic             flush_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             squash_pending,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  // Handshake: a cache request is outstanding while *_read/*_write is high and
  // completes in the cycle its *_resp is high; until then the stage is stalled.

  pctrl_state_t state_q;
  pctrl_state_t state_d;
  rv32i_word    redir_q;
  rv32i_word    redir_d;
  logic         imem_stall;
  logic         dmem_stall;
  logic         hazard;
  logic         flush_inc;
  logic         stall_inc;
  logic         id_is_load;

  assign imem_stall = i_mem_read && !i_mem_resp;
  assign dmem_stall = (d_mem_read || d_mem_write) && !d_mem_resp;
  assign stall_inc  = (imem_stall || dmem_stall) && !rst;

  // The ID opcode is not needed for the compare; kept on the port for tracing.
  assign id_is_load = is_load(id_opcode);

  hazard_detect u_hazard_detect (
    .ex_opcode   (ex_opcode),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .hazard      (hazard)
  );

  assign squash_pending  = (state_q == SQUASH);
  assign pc_redirect_out = (state_q == SQUASH) ? redir_q : ex_target;

  always_comb begin
    load_pc         = 1'b1;
    pc_redirect_sel = 1'b0;
    load_if_id      = 1'b1;
    flush_if_id     = 1'b0;
    load_id_ex      = 1'b1;
    flush_id_ex     = 1'b0;
    load_ex_mem     = 1'b1;
    load_mem_wb     = 1'b1;
    state_d         = state_q;
    redir_d         = redir_q;
    flush_inc       = 1'b0;

    if (rst) begin
      load_pc     = 1'b0;
      load_if_id  = 1'b0;
      load_id_ex  = 1'b0;
      load_ex_mem = 1'b0;
      load_mem_wb = 1'b0;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
      state_d     = RUN;
    end else if (dmem_stall) begin
      // Whole pipe frozen; EX holds, so a mispredict reappears once it moves.
      load_pc     = 1'b0;
      load_if_id  = 1'b0;
      load_id_ex  = 1'b0;
      load_ex_mem = 1'b0;
      load_mem_wb = 1'b0;
      // The pending redirect still lands when the I-miss returns, since IF is
      // independent of the D-side freeze.
      if (state_q == SQUASH && i_mem_resp) begin
        load_pc         = 1'b1;
        pc_redirect_sel = 1'b1;
        flush_if_id     = 1'b1;
        state_d         = RUN;
      end
    end else begin
      unique case (state_q)
        RUN: begin
          if (ex_mispredict) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            flush_inc   = 1'b1;
            if (imem_stall) begin
              load_pc = 1'b0;
              redir_d = ex_target;
              state_d = SQUASH;
            end else begin
              pc_redirect_sel = 1'b1;
            end
          end else if (hazard) begin
            load_pc     = 1'b0;
            load_if_id  = 1'b0;
            flush_id_ex = 1'b1;
          end else if (imem_stall) begin
            load_pc     = 1'b0;
            flush_if_id = 1'b1;
          end
        end
        SQUASH: begin
          // Whatever the in-flight fetch returns is wrong-path; drop it.
          flush_if_id = 1'b1;
          if (i_mem_resp) begin
            pc_redirect_sel = 1'b1;
            state_d         = RUN;
          end else begin
            load_pc = 1'b0;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      redir_q     <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state_q <= state_d;
      redir_q <= redir_d;
      if (stall_inc) stall_count <= stall_count + CNT_W'(1);
      if (flush_inc) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios then random traffic against a
// cycle-level reference model of the stall/flush rules.
module tb_pipeline_ctrl;
  import rv32i_types::*;

  localparam int CNT_W = 32;

  logic             clk;
  logic             rst;
  logic             i_mem_read, i_mem_resp;
  logic             d_mem_read, d_mem_write, d_mem_resp;
  rv32i_opcode      id_opcode, ex_opcode;
  rv32i_reg         id_rs1, id_rs2, ex_rd;
  logic             id_uses_rs1, id_uses_rs2;
  logic             ex_mispredict;
  rv32i_word        ex_target;
  logic             load_pc, pc_redirect_sel;
  rv32i_word        pc_redirect_out;
  logic             load_if_id, flush_if_id, load_id_ex, flush_id_ex;
  logic             load_ex_mem, load_mem_wb, squash_pending;
  logic [CNT_W-1:0] stall_count, flush_count;

  pipeline_ctrl #(.CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_mem_read      (i_mem_read),
    .i_mem_resp      (i_mem_resp),
    .d_mem_read      (d_mem_read),
    .d_mem_write     (d_mem_write),
    .d_mem_resp      (d_mem_resp),
    .id_opcode       (id_opcode),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .ex_opcode       (ex_opcode),
    .ex_rd           (ex_rd),
    .ex_mispredict   (ex_mispredict),
    .ex_target       (ex_target),
    .load_pc         (load_pc),
    .pc_redirect_sel (pc_redirect_sel),
    .pc_redirect_out (pc_redirect_out),
    .load_if_id      (load_if_id),
    .flush_if_id     (flush_if_id),
    .load_id_ex      (load_id_ex),
    .flush_id_ex     (flush_id_ex),
    .load_ex_mem     (load_ex_mem),
    .load_mem_wb     (load_mem_wb),
    .squash_pending  (squash_pending),
    .stall_count     (stall_count),
    .flush_count     (flush_count)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_squash;
  logic [31:0] m_redir;
  logic [31:0] m_stall;
  logic [31:0] m_flush;

  function automatic bit tb_hazard();
    return ex_opcode == op_load && ex_rd != 0 &&
           ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
  endfunction

  // Expected controls ordered {pc, sel, lif, fif, lie, fie, lem, lmw, squash}.
  task automatic predict();
    bit imem, dmem, haz;
    bit lp, sel, lif, fif, lie, fie, lem, lmw;
    imem = i_mem_read && !i_mem_resp;
    dmem = (d_mem_read || d_mem_write) && !d_mem_resp;
    haz  = tb_hazard();
    {lp, lif, lie, lem, lmw} = 5'b11111;
    {sel, fif, fie} = 3'b000;
    if (rst) begin
      {lp, lif, lie, lem, lmw} = 5'b00000;
      fif = 1; fie = 1;
    end else if (dmem) begin
      {lp, lif, lie, lem, lmw} = 5'b00000;
      if (m_squash && i_mem_resp) begin lp = 1; sel = 1; fif = 1; end
    end else if (m_squash) begin
      fif = 1;
      lp  = i_mem_resp;
      sel = i_mem_resp;
    end else if (ex_mispredict) begin
      fif = 1; fie = 1;
      if (imem) lp = 0; else sel = 1;
    end else if (haz) begin
      lp = 0; lif = 0; fie = 1;
    end else if (imem) begin
      lp = 0; fif = 1;
    end
    exp_q.push_back({55'd0, lp, sel, lif, fif, lie, fie, lem, lmw, m_squash});
    exp_q.push_back({32'd0, m_squash ? m_redir : ex_target});
    exp_q.push_back({32'd0, m_stall});
    exp_q.push_back({32'd0, m_flush});
  endtask

  task automatic advance_model();
    bit imem, dmem;
    imem = i_mem_read && !i_mem_resp;
    dmem = (d_mem_read || d_mem_write) && !d_mem_resp;
    if (rst) begin
      m_squash = 0; m_redir = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (imem || dmem) m_stall++;
      if (m_squash) begin
        if (i_mem_resp) m_squash = 0;
      end else if (!dmem && ex_mispredict) begin
        m_flush++;
        if (imem) begin m_squash = 1; m_redir = ex_target; end
      end
    end
  endtask

  // Inputs are already driven (just after negedge); compare, then clock once.
  task automatic cycle();
    logic [63:0] e;
    predict();
    #1;
    e = exp_q.pop_front();
    check("ctrl", {55'd0, load_pc, pc_redirect_sel, load_if_id, flush_if_id, load_id_ex,
                   flush_id_ex, load_ex_mem, load_mem_wb, squash_pending}, e);
    e = exp_q.pop_front();
    check("redirect_pc", {32'd0, pc_redirect_out}, e);
    e = exp_q.pop_front();
    check("stall_count", {32'd0, stall_count}, e);
    e = exp_q.pop_front();
    check("flush_count", {32'd0, flush_count}, e);
    @(posedge clk);
    advance_model();
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    rst = 0;
    i_mem_read = 1; i_mem_resp = 1;
    d_mem_read = 0; d_mem_write = 0; d_mem_resp = 0;
    id_opcode = op_imm; ex_opcode = op_imm;
    id_rs1 = 5'd1; id_rs2 = 5'd2; ex_rd = 5'd3;
    id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_mispredict = 0; ex_target = 32'h0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1;
    cycle();
    rst = 0;
  endtask

  rv32i_opcode ops[6] = '{op_load, op_load, op_imm, op_reg, op_br, op_store};

  task automatic drive_random();
    drive_idle();
    rst         = ($urandom_range(0, 199) == 0);
    i_mem_read  = ($urandom_range(0, 9) != 0);
    i_mem_resp  = ($urandom_range(0, 9) < 4);
    d_mem_read  = ($urandom_range(0, 9) == 0);
    d_mem_write = ($urandom_range(0, 9) == 0);
    d_mem_resp  = $urandom_range(0, 1);
    id_opcode   = ops[$urandom_range(0, 5)];
    ex_rd       = 5'($urandom_range(0, 3));
    id_rs1      = 5'($urandom_range(0, 3));
    id_rs2      = 5'($urandom_range(0, 3));
    id_uses_rs1 = $urandom_range(0, 1);
    id_uses_rs2 = $urandom_range(0, 1);
    ex_target   = $urandom;
    // Only bubbles follow a squashed branch, so EX is quiet in SQUASH.
    if (m_squash) begin
      ex_opcode     = op_imm;
      ex_mispredict = 0;
    end else begin
      ex_opcode     = ops[$urandom_range(0, 5)];
      ex_mispredict = ($urandom_range(0, 9) < 2);
    end
  endtask

  // SQUASH must never see a live mispredict or load-use hazard.
  always @(posedge clk) begin
    if (squash_pending && !rst)
      assert (!ex_mispredict && !tb_hazard()) else $error("illegal EX activity in SQUASH");
  end

  // ---------------- stimulus ----------------
  initial begin
    drive_idle();
    rst = 1;
    m_squash = 0; m_redir = 0; m_stall = 0; m_flush = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cycle();                       // reset-state outputs
    rst = 0;

    // No stalls
    repeat (10) cycle();
    check("idle_stalls", {32'd0, stall_count}, 64'd0);

    // Load-use on rs2, then same with ex_rd = x0
    ex_opcode = op_load; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1;
    #1 check("loaduse_if_id", {63'd0, load_if_id}, 64'd0);
    cycle();
    ex_rd = 5'd0; id_rs2 = 5'd0;
    #1 check("loaduse_x0_pc", {63'd0, load_pc}, 64'd1);
    cycle();
    drive_idle();

    // Mispredict in RUN
    ex_mispredict = 1; ex_target = 32'h80;
    #1 check("mp_redirect", {32'd0, pc_redirect_out}, 64'h80);
    cycle();
    check("mp_flush_count", {32'd0, flush_count}, 64'd1);
    drive_idle();

    // Deferred redirect across a 4-cycle I-miss
    i_mem_resp = 0; ex_mispredict = 1; ex_target = 32'h200;
    cycle();
    ex_mispredict = 0; ex_target = 32'h444;
    check("sq_entered", {63'd0, squash_pending}, 64'd1);
    repeat (3) cycle();
    i_mem_resp = 1;
    #1 check("sq_exit_pc", {32'd0, pc_redirect_out}, 64'h200);
    cycle();
    check("sq_left", {63'd0, squash_pending}, 64'd0);
    cycle();

    // D-miss freeze with a mispredict waiting in EX
    do_reset();
    d_mem_read = 1; ex_mispredict = 1; ex_target = 32'h1234;
    repeat (3) cycle();
    d_mem_resp = 1;
    #1 check("dmiss_release_sel", {63'd0, pc_redirect_sel}, 64'd1);
    cycle();
    check("dmiss_stall_count", {32'd0, stall_count}, 64'd3);
    drive_idle();

    // Reset while a redirect is pending
    i_mem_resp = 0; ex_mispredict = 1; ex_target = 32'h300;
    cycle();
    drive_idle();
    i_mem_resp = 0;
    cycle();
    rst = 1;
    cycle();
    rst = 0; i_mem_resp = 1;
    check("rst_sq_state", {63'd0, squash_pending}, 64'd0);
    check("rst_sq_flush", {32'd0, flush_count}, 64'd0);
    cycle();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
